rnn_seq_driver: RTL and testbench
=================================

// Module: rnn_seq_driver
// PURPOSE
//   Bus initiator that drives the RNN accelerator's slave port (read/write/addr/data) on behalf of a host.
//   Per command: optionally copies parameter words from a sync ROM into the accelerator (addr 2..6),
//   streams N embedding vectors (addr 1 writes + addr 0 start, fixed step wait), then fires the dense pass
//   (addr 7 write), polls addr 0 until valid, reads addr 7 and returns the 16-bit result by valid/ready.
// PARAMETERS
//   EMB_LEN      4     elements per embedding vector (16-bit each)
//   PARAM_WORDS  128   ROM entries copied when cmd_load=1
//   PADDR_BITS   7     ROM address width, = $clog2(PARAM_WORDS)
//   STEP_WAIT    1200  idle cycles after each addr-0 start before the next bus access
//   POLL_TIMEOUT 255   max addr-0 polls before giving up
// PORTS
//   clk          in   1              clock, all logic on posedge
//   rst          in   1              async, active-high reset
//   cmd_valid    in   1              host command request
//   cmd_ready    out  1              high only in IDLE
//   cmd_load     in   1              1: copy parameter ROM first
//   cmd_len      in   8              number of characters (0 allowed)
//   rom_addr     out  PADDR_BITS     parameter ROM address, data returned next cycle
//   rom_data     in   35             {tgt[2:0], row[7:0], col/idx[7:0], value[15:0]}
//   ch_valid     in   1              embedding vector available
//   ch_ready     out  1              high only in CH_WAIT
//   ch_data      in   16*EMB_LEN     element i at [16*i +: 16]
//   m_read       out  1              accelerator read strobe
//   m_write      out  1              accelerator write strobe
//   m_addr       out  32             accelerator address
//   m_wdata      out  32             accelerator write data
//   m_rdata      in   32             accelerator read data, valid in same cycle as m_read
//   res_valid    out  1              result held until res_ready
//   res_ready    in   1              host accepts result
//   res_data     out  16             m_rdata[15:0] from addr-7 read; 0 on timeout
//   res_timeout  out  1              qualifies res_data: poll limit hit
//   busy         out  1              state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0 except cmd_ready=1; counters 0. Reset mid-run aborts immediately,
//     bus strobes drop to 0. Accelerator state is not repaired; host resets both.
//   - All outputs registered (decoded from state/counter regs). m_read and m_write never both 1.
//     Bus is idle (strobes 0, addr/wdata 0) in every state not listed as issuing.
//   - IDLE: cmd_valid & cmd_ready latches cmd_load/cmd_len -> P_REQ if cmd_load,
//     else CH_WAIT if len>0, else DENSE_GO.
//   - P_REQ: drive rom_addr=p -> P_WR (2 cycles per entry).
//   - P_WR: if tgt in 2..6 issue m_write, m_addr={29'b0,tgt}, m_wdata=rom_data[31:0]; tgt 0/1/7 is skipped,
//     no write. p==PARAM_WORDS-1 -> (len>0 ? CH_WAIT : DENSE_GO); else p++ -> P_REQ.
//   - CH_WAIT: ch_ready=1; on handshake capture ch_data -> CH_WR with e=0.
//   - CH_WR: one write per cycle, m_addr=1, m_wdata={8'h00, e[7:0], elem[e]}.
//     After e==EMB_LEN-1 -> STEP_GO.
//   - STEP_GO: one cycle m_write, m_addr=0, m_wdata=0 -> STEP_WAIT (cnt=0).
//   - STEP_WAIT: bus idle for exactly STEP_WAIT cycles. Then chars_done++; done==len ? DENSE_GO : CH_WAIT.
//   - DENSE_GO: one cycle m_write, m_addr=7, m_wdata=0 -> POLL (polls=0).
//   - POLL: m_read, m_addr=0 each cycle. m_rdata[0]=1 -> RD_RES.
//     Else polls++; polls==POLL_TIMEOUT-1 -> OUT with res_timeout=1, res_data=0.
//   - RD_RES: one cycle m_read, m_addr=7; capture m_rdata[15:0] -> OUT.
//   - OUT: res_valid=1, data stable; on res_ready -> IDLE (res_valid, res_timeout cleared).
//     res_ready while not OUT is ignored.
//   - cmd_valid outside IDLE is ignored (not queued). ch_valid outside CH_WAIT is ignored.
//   - Counters: p PADDR_BITS, e $clog2(EMB_LEN)+1, chars 8b, wait/poll sized for params; no wrap in legal use.
// TESTING
//   1. cmd_load=1, len=0, ROM[0]={3'd6,8'h0,8'h0,16'h0100}, others tgt=0 ->
//      single write addr 6 data 0x0000_0100, then addr-7 write.
//   2. ROM entry tgt=1 or 7 -> no bus write in its P_WR cycle, p still advances.
//   3. cmd_load=0, len=2, vectors {1,2,3,4},{5,6,7,8} -> writes addr1 0x0000_0001, 0x0001_0002...;
//      addr0 start; exactly STEP_WAIT idle cycles; repeat; then addr7 write.
//   4. Slave model returns addr0=0 for 3 polls then 1, addr7=0xFFFF_8001 ->
//      res_data=16'h8001, res_timeout=0, held 5 cycles until res_ready.
//   5. addr0 never 1 -> exactly POLL_TIMEOUT reads, then res_valid=1, res_timeout=1, res_data=0.
//   6. rst asserted during STEP_WAIT and during POLL -> next cycle all strobes 0, cmd_ready=1, busy=0;
//      new command runs cleanly.

Source files
------------

// File: rtl/rnn_seq_driver.sv
// rnn_seq_driver: bus initiator that sequences the RNN accelerator for a host.
// For each command it can copy the parameter ROM into the accelerator, then it
// streams cmd_len embedding vectors, fires the dense pass, polls for
// completion and returns the 16-bit result over a valid/ready handshake.
// Ports:
//   clk, rst                     clock, async active-high reset
//   cmd_valid/ready/load/len     host command handshake
//   rom_addr, rom_data           synchronous parameter ROM (1-cycle latency)
//   ch_valid/ready/data          embedding vector stream
//   m_read/write/addr/wdata/rdata accelerator slave bus (rdata same cycle)
//   res_valid/ready/data/timeout result handshake
//   busy                         high whenever not idle
module rnn_seq_driver #(
   parameter int unsigned EMB_LEN      = 4,
   parameter int unsigned PARAM_WORDS  = 128,
   parameter int unsigned PADDR_BITS   = 7,
   parameter int unsigned STEP_WAIT    = 1200,
   parameter int unsigned POLL_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_load,
   input  logic [7:0]              cmd_len,
   output logic [PADDR_BITS-1:0]   rom_addr,
   input  logic [34:0]             rom_data,
   input  logic                    ch_valid,
   output logic                    ch_ready,
   input  logic [16*EMB_LEN-1:0]   ch_data,
   output logic                    m_read,
   output logic                    m_write,
   output logic [31:0]             m_addr,
   output logic [31:0]             m_wdata,
   input  logic [31:0]             m_rdata,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [15:0]             res_data,
   output logic                    res_timeout,
   output logic                    busy
);

   localparam int unsigned VEC_W  = 16 * EMB_LEN;
   localparam int unsigned E_BITS = $clog2(EMB_LEN) + 1;
   localparam int unsigned W_BITS = $clog2(STEP_WAIT + 1);
   localparam int unsigned P_BITS = $clog2(POLL_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_P_REQ, S_P_WR, S_CH_WAIT, S_CH_WR, S_STEP_GO,
      S_STEP_WAIT, S_DENSE_GO, S_POLL, S_RD_RES, S_OUT
   } state_t;

   state_t                  state_q, state_d;
   logic [PADDR_BITS-1:0]   p_q, p_d;
   logic [E_BITS-1:0]       e_q, e_d;
   logic [7:0]              chars_q, chars_d;
   logic [W_BITS-1:0]       wcnt_q, wcnt_d;
   logic [P_BITS-1:0]       polls_q, polls_d;
   logic [7:0]              len_q, len_d;
   logic [VEC_W-1:0]        vec_q, vec_d;

   logic                    cmd_ready_q, cmd_ready_d;
   logic                    ch_ready_q, ch_ready_d;
   logic [PADDR_BITS-1:0]   rom_addr_q, rom_addr_d;
   logic                    m_read_q, m_read_d;
   logic                    m_write_q, m_write_d;
   logic [31:0]             m_addr_q, m_addr_d;
   logic [31:0]             m_wdata_q, m_wdata_d;
   logic                    res_valid_q, res_valid_d;
   logic [15:0]             res_data_q, res_data_d;
   logic                    res_timeout_q, res_timeout_d;
   logic                    busy_q, busy_d;

   logic [2:0]              tgt;
   int unsigned             eidx;

   // Next-state / counter logic, then registered outputs decoded from the next state.
   always_comb begin
      state_d       = state_q;
      p_d           = p_q;
      e_d           = e_q;
      chars_d       = chars_q;
      wcnt_d        = wcnt_q;
      polls_d       = polls_q;
      len_d         = len_q;
      vec_d         = vec_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      tgt           = rom_data[34:32];
      eidx          = 0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               len_d   = cmd_len;
               p_d     = '0;
               chars_d = '0;
               if (cmd_load)           state_d = S_P_REQ;
               else if (cmd_len != 0)  state_d = S_CH_WAIT;
               else                    state_d = S_DENSE_GO;
            end
         end
         S_P_REQ: state_d = S_P_WR;
         S_P_WR: begin
            if (p_q == PADDR_BITS'(PARAM_WORDS - 1)) begin
               state_d = (len_q != 0) ? S_CH_WAIT : S_DENSE_GO;
            end else begin
               p_d     = p_q + PADDR_BITS'(1);
               state_d = S_P_REQ;
            end
         end
         S_CH_WAIT: begin
            if (ch_valid) begin
               vec_d   = ch_data;
               e_d     = '0;
               state_d = S_CH_WR;
            end
         end
         S_CH_WR: begin
            if (e_q == E_BITS'(EMB_LEN - 1)) state_d = S_STEP_GO;
            else                             e_d = e_q + E_BITS'(1);
         end
         S_STEP_GO: begin
            wcnt_d  = '0;
            state_d = S_STEP_WAIT;
         end
         S_STEP_WAIT: begin
            if (wcnt_q == W_BITS'(STEP_WAIT - 1)) begin
               chars_d = chars_q + 8'd1;
               state_d = (chars_d == len_q) ? S_DENSE_GO : S_CH_WAIT;
            end else begin
               wcnt_d = wcnt_q + W_BITS'(1);
            end
         end
         S_DENSE_GO: begin
            polls_d = '0;
            state_d = S_POLL;
         end
         S_POLL: begin
            if (m_rdata[0]) begin
               state_d = S_RD_RES;
            end else if (polls_q == P_BITS'(POLL_TIMEOUT - 1)) begin
               res_timeout_d = 1'b1;
               res_data_d    = 16'h0000;
               state_d       = S_OUT;
            end else begin
               polls_d = polls_q + P_BITS'(1);
            end
         end
         S_RD_RES: begin
            res_data_d    = m_rdata[15:0];
            res_timeout_d = 1'b0;
            state_d       = S_OUT;
         end
         S_OUT: begin
            if (res_ready) begin
               res_data_d    = 16'h0000;
               res_timeout_d = 1'b0;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      ch_ready_d  = (state_d == S_CH_WAIT);
      res_valid_d = (state_d == S_OUT);

      // ROM address runs one entry ahead during P_WR so the word for the next
      // P_WR is already on rom_data in its P_REQ cycle (IDLE presents entry 0).
      rom_addr_d = '0;
      if (state_d == S_P_REQ)     rom_addr_d = p_d;
      else if (state_d == S_P_WR) rom_addr_d = p_d + PADDR_BITS'(1);

      m_read_d  = 1'b0;
      m_write_d = 1'b0;
      m_addr_d  = '0;
      m_wdata_d = '0;
      case (state_d)
         S_P_WR: begin
            if ((tgt >= 3'd2) && (tgt <= 3'd6)) begin
               m_write_d = 1'b1;
               m_addr_d  = {29'b0, tgt};
               m_wdata_d = rom_data[31:0];
            end
         end
         S_CH_WR: begin
            eidx      = 32'(e_d);
            m_write_d = 1'b1;
            m_addr_d  = 32'd1;
            m_wdata_d = {8'h00, 8'(e_d), vec_d[eidx*16 +: 16]};
         end
         S_STEP_GO: begin
            m_write_d = 1'b1;
         end
         S_DENSE_GO: begin
            m_write_d = 1'b1;
            m_addr_d  = 32'd7;
         end
         S_POLL: begin
            m_read_d = 1'b1;
         end
         S_RD_RES: begin
            m_read_d = 1'b1;
            m_addr_d = 32'd7;
         end
         default: ;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         p_q           <= '0;
         e_q           <= '0;
         chars_q       <= '0;
         wcnt_q        <= '0;
         polls_q       <= '0;
         len_q         <= '0;
         vec_q         <= '0;
         cmd_ready_q   <= 1'b1;
         ch_ready_q    <= 1'b0;
         rom_addr_q    <= '0;
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_addr_q      <= '0;
         m_wdata_q     <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_q           <= p_d;
         e_q           <= e_d;
         chars_q       <= chars_d;
         wcnt_q        <= wcnt_d;
         polls_q       <= polls_d;
         len_q         <= len_d;
         vec_q         <= vec_d;
         cmd_ready_q   <= cmd_ready_d;
         ch_ready_q    <= ch_ready_d;
         rom_addr_q    <= rom_addr_d;
         m_read_q      <= m_read_d;
         m_write_q     <= m_write_d;
         m_addr_q      <= m_addr_d;
         m_wdata_q     <= m_wdata_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign ch_ready    = ch_ready_q;
   assign rom_addr    = rom_addr_q;
   assign m_read      = m_read_q;
   assign m_write     = m_write_q;
   assign m_addr      = m_addr_q;
   assign m_wdata     = m_wdata_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_rnn_seq_driver.sv
// tb_rnn_seq_driver: directed bench for rnn_seq_driver with a ROM model,
// an accelerator slave model and a bus write/read monitor.
module tb_rnn_seq_driver;

   localparam int unsigned EMB_LEN      = 4;
   localparam int unsigned PARAM_WORDS  = 128;
   localparam int unsigned PADDR_BITS   = 7;
   localparam int unsigned STEP_WAIT    = 1200;
   localparam int unsigned POLL_TIMEOUT = 255;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cmd_valid, cmd_ready, cmd_load;
   logic [7:0]            cmd_len;
   logic [PADDR_BITS-1:0] rom_addr;
   logic [34:0]           rom_data;
   logic                  ch_valid, ch_ready;
   logic [63:0]           ch_data;
   logic                  m_read, m_write;
   logic [31:0]           m_addr, m_wdata, m_rdata;
   logic                  res_valid, res_ready, res_timeout, busy;
   logic [15:0]           res_data;

   rnn_seq_driver #(
      .EMB_LEN(EMB_LEN), .PARAM_WORDS(PARAM_WORDS), .PADDR_BITS(PADDR_BITS),
      .STEP_WAIT(STEP_WAIT), .POLL_TIMEOUT(POLL_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_len(cmd_len),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Parameter ROM, one cycle read latency.
   logic [34:0] rom [PARAM_WORDS];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Vector source: advances on each accepted handshake.
   logic [63:0] vecs [4];
   int          vidx = 0;
   always @(posedge clk) if (ch_valid && ch_ready) vidx <= vidx + 1;
   assign ch_data = vecs[vidx % 4];

   // Slave model: addr0 reads report done after ready_after prior polls.
   int ready_after = 0;
   int polls_seen  = 0;
   always @(posedge clk) if (m_read && m_addr == 32'd0) polls_seen = polls_seen + 1;
   always_comb begin
      m_rdata = 32'h0;
      if (m_read && m_addr == 32'd0) m_rdata = {31'b0, (polls_seen >= ready_after)};
      else if (m_read && m_addr == 32'd7) m_rdata = 32'hFFFF_8001;
   end

   // Bus monitor.
   int          cyc = 0;
   logic [31:0] wq_addr [$];
   logic [31:0] wq_data [$];
   int          wq_cyc  [$];
   int          rd0 = 0, rd7 = 0;
   logic        both_seen = 1'b0;
   always @(posedge clk) cyc = cyc + 1;
   always @(negedge clk) begin
      if (m_read && m_write) both_seen = 1'b1;
      if (m_write) begin
         wq_addr.push_back(m_addr);
         wq_data.push_back(m_wdata);
         wq_cyc.push_back(cyc);
      end
      if (m_read && m_addr == 32'd0) rd0 = rd0 + 1;
      if (m_read && m_addr == 32'd7) rd7 = rd7 + 1;
   end

   task automatic clear_mon();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
      rd0        = 0;
      rd7        = 0;
      polls_seen = 0;
   endtask

   task automatic issue(input logic load, input logic [7:0] len);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_load  = load;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_res(input int budget);
      int n = 0;
      while (!res_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) chk("res_wait_timeout", 64'(res_valid), 64'd1);
   endtask

   task automatic accept();
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("acc_res_valid", 64'(res_valid), 64'd0);
      chk("acc_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_m_read"},    64'(m_read),    64'd0);
      chk({tag, "_m_write"},   64'(m_write),   64'd0);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_busy"},      64'(busy),      64'd0);
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
      if (i < wq_addr.size()) begin
         chk($sformatf("%s_addr%0d", tag, i), 64'(wq_addr[i]), 64'(a));
         chk($sformatf("%s_data%0d", tag, i), 64'(wq_data[i]), 64'(d));
      end else begin
         chk($sformatf("%s_missing%0d", tag, i), 64'(wq_addr.size()), 64'(i + 1));
      end
   endtask

   logic [31:0] exp_a [11];
   logic [31:0] exp_d [11];

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_len = 8'd0;
      ch_valid = 1'b0; res_ready = 1'b0;
      for (int i = 0; i < int'(PARAM_WORDS); i++) rom[i] = 35'd0;
      rom[0]   = {3'd6, 8'h00, 8'h00, 16'h0100};
      rom[5]   = {3'd1, 8'h11, 8'h22, 16'h3333};
      rom[9]   = {3'd7, 8'h44, 8'h55, 16'h6666};
      rom[127] = {3'd2, 8'hAA, 8'h12, 16'h5678};
      vecs[0] = {16'd4, 16'd3, 16'd2, 16'd1};
      vecs[1] = {16'd8, 16'd7, 16'd6, 16'd5};
      vecs[2] = 64'h0;
      vecs[3] = 64'h0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_idle("rst");
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_ch_ready",  64'(ch_ready),  64'd0);
      chk("rst_rom_addr",  64'(rom_addr),  64'd0);
      rst = 1'b0;

      // ROM copy: tgt 6 written, tgt 0/1/7 skipped, last entry written
      clear_mon();
      ready_after = 0;
      issue(1'b1, 8'd0);
      wait_res(2000);
      chk("t1_nwr", 64'(wq_addr.size()), 64'd3);
      chk_wr("t1", 0, 32'd6, 32'h0000_0100);
      chk_wr("t1", 1, 32'd2, 32'hAA12_5678);
      chk_wr("t1", 2, 32'd7, 32'h0);
      if (wq_cyc.size() >= 2) chk("t1_p_gap", 64'(wq_cyc[1] - wq_cyc[0]), 64'd254);
      chk("t1_rd0", 64'(rd0), 64'd1);
      chk("t1_res", 64'(res_data), 64'h8001);
      chk("t1_tmo", 64'(res_timeout), 64'd0);
      accept();

      // Two vectors, step waits, 3 not-ready polls, held result
      clear_mon();
      ready_after = 3;
      ch_valid    = 1'b1;
      issue(1'b0, 8'd2);
      wait_res(5000);
      for (int i = 0; i < 4; i++) begin
         exp_a[i]     = 32'd1; exp_d[i]     = {8'h00, 8'(i), 16'(i + 1)};
         exp_a[i + 5] = 32'd1; exp_d[i + 5] = {8'h00, 8'(i), 16'(i + 5)};
      end
      exp_a[4] = 32'd0; exp_d[4] = 32'd0;
      exp_a[9] = 32'd0; exp_d[9] = 32'd0;
      exp_a[10] = 32'd7; exp_d[10] = 32'd0;
      chk("t3_nwr", 64'(wq_addr.size()), 64'd11);
      for (int i = 0; i < 11; i++) chk_wr("t3", i, exp_a[i], exp_d[i]);
      if (wq_cyc.size() == 11) begin
         chk("t3_gap_mid",  64'(wq_cyc[5] - wq_cyc[4]),  64'(STEP_WAIT + 2));
         chk("t3_gap_last", 64'(wq_cyc[10] - wq_cyc[9]), 64'(STEP_WAIT + 1));
         chk("t3_b2b",      64'(wq_cyc[3] - wq_cyc[0]),  64'd3);
      end
      chk("t3_vecs", 64'(vidx), 64'd2);
      chk("t4_rd0", 64'(rd0), 64'd4);
      chk("t4_rd7", 64'(rd7), 64'd1);
      chk("t4_res", 64'(res_data), 64'h8001);
      chk("t4_tmo", 64'(res_timeout), 64'd0);
      begin
         int held = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid && res_data == 16'h8001 && !m_read && !m_write) held++;
         end
         chk("t4_held5", 64'(held), 64'd5);
      end
      accept();
      ch_valid = 1'b0;

      // Poll timeout
      clear_mon();
      ready_after = 100000;
      issue(1'b0, 8'd0);
      wait_res(1000);
      chk("t5_rd0", 64'(rd0), 64'(POLL_TIMEOUT));
      chk("t5_valid", 64'(res_valid), 64'd1);
      chk("t5_tmo", 64'(res_timeout), 64'd1);
      chk("t5_res", 64'(res_data), 64'h0);
      chk("t5_rd7", 64'(rd7), 64'd0);
      accept();
      chk("t5_tmo_clr", 64'(res_timeout), 64'd0);

      // Reset during STEP_WAIT
      clear_mon();
      ch_valid = 1'b1;
      issue(1'b0, 8'd1);
      begin
         int n = 0;
         while (wq_addr.size() < 5 && n < 100) begin @(negedge clk); n++; end
         chk("t6a_reached", 64'(wq_addr.size()), 64'd5);
      end
      repeat (10) @(negedge clk);
      chk("t6a_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("t6a");
      rst = 1'b0;
      ch_valid = 1'b0;

      // Reset during POLL
      clear_mon();
      ready_after = 100000;
      issue(1'b0, 8'd0);
      begin
         int n = 0;
         while (rd0 < 10 && n < 100) begin @(negedge clk); n++; end
         chk("t6b_polling", 64'(m_read), 64'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk_idle("t6b");
      rst = 1'b0;

      // Clean command after reset
      @(negedge clk);
      clear_mon();
      ready_after = 0;
      issue(1'b0, 8'd0);
      wait_res(100);
      chk("t6c_nwr", 64'(wq_addr.size()), 64'd1);
      chk_wr("t6c", 0, 32'd7, 32'h0);
      chk("t6c_res", 64'(res_data), 64'h8001);
      accept();

      chk("excl_strobes", 64'(both_seen), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
